pixel_pingpong_buffer: RTL and testbench
========================================

// Module: pixel_pingpong_buffer
// PURPOSE
// Parametrised successor to the single-bank pixel SRAM. An Avalon-MM burst-write slave unpacks 32-bit
// words into PIXEL_W pixels and writes them into one of two on-chip banks. NUM_RD read ports serve the
// network from the other bank. Completing a burst swaps the banks, so the next image loads while
// inference runs.
// PARAMETERS
// PIXEL_W  8    pixel width in bits; must be 8 or 16; PPW = 32/PIXEL_W pixels per word
// DEPTH    784  pixels per bank; must be a multiple of PPW; NWORDS = DEPTH/PPW
// NUM_RD   2    number of independent pixel read ports
// BC_W     10   burstcount width
// AW       13   Avalon word-address width; PAW = $clog2(DEPTH) pixel-address width
// PORTS
// clk                     in   1            system clock, rising edge
// rst                     in   1            synchronous reset, active high
// avs_write               in   1            Avalon write request
// avs_beginbursttransfer  in   1            first cycle of a burst
// avs_burstcount          in   BC_W         words in burst, sampled with beginbursttransfer
// avs_address             in   AW           start word address, sampled with beginbursttransfer
// avs_writedata           in   32           packed pixels; pixel k = writedata[k*PIXEL_W +: PIXEL_W]
// avs_waitrequest         out  1            1 = word not accepted this cycle
// rd_hold                 in   1            reader busy; blocks the bank swap
// rd_en                   in   1            read strobe for all ports
// rd_addr                 in   NUM_RD*PAW   per-port pixel address, port j in slice j
// rd_data                 out  NUM_RD*PIXEL_W  per-port pixel, registered
// rd_valid                out  1            rd_data valid; 1 cycle after rd_en
// load_busy               out  1            burst in progress (state BURST or SWAP)
// load_done               out  1            1-cycle pulse on bank swap
// overflow                out  1            sticky: a word addressed >= NWORDS was dropped
// BEHAVIOUR
// - Reset: waitrequest=1 during the rst cycle, 0 from the next cycle; load_busy=0, load_done=0,
//   overflow=0, rd_valid=0, rd_data=0, rd_bank=0 (write bank = 1). Reset does not clear memory.
// - FSM states: IDLE, BURST, SWAP.
// - IDLE, waitrequest=0:
//   - write & beginbursttransfer & burstcount>=1: the first word is accepted this cycle at word address
//     avs_address. wptr=avs_address+1, remaining=burstcount-1. Go to BURST; if remaining=0, go to SWAP.
//   - burstcount=0, or write without beginbursttransfer: ignored; no state change.
// - BURST, waitrequest=0:
//   - Each cycle with write=1 accepts one word at wptr; then wptr++ and remaining--.
//   - write=0 inserts a gap; there is no timeout. beginbursttransfer is ignored (the word is data).
//   - The last word is accepted, then go to SWAP.
// - Word store: pixel k of word w goes to pixel index w*PPW+k of the write bank, written at the
//   accepting edge. If w >= NWORDS the word is dropped, overflow<=1, and the burst still counts down.
// - SWAP, waitrequest=1:
//   - If rd_hold=0: toggle rd_bank, load_done=1 for exactly this cycle, then go to IDLE.
//   - If rd_hold=1: stay in SWAP; new bursts are stalled.
//   - Min latency: load_done is asserted the cycle after the last word is accepted.
// - Read, 1-cycle latency: rd_en at edge N -> rd_data[j] = read-bank pixel at rd_addr[j] and rd_valid=1
//   after edge N+1.
//   - rd_data holds its value while rd_en=0. rd_addr >= DEPTH returns 0.
//   - A read sampled at the same edge as the swap returns the pre-swap bank.
//   - A write to the write bank never affects the read bank.
// - Reset mid-burst aborts it: there is no swap, the read bank and its data are untouched, and partial
//   writes remain in the write bank.
// - overflow clears only on rst.
// TESTING
// 1. rst high 2 cycles then low -> waitrequest 1 then 0; load_busy, load_done, overflow, rd_valid all 0.
// 2. PIXEL_W=8 burst at addr 0, count 196, word i = {4i+3,4i+2,4i+1,4i} mod 256 -> one load_done pulse
//    the cycle after word 195; then rd_en with rd_addr={783,5} -> rd_data={8'd15,8'd5}, rd_valid=1 next cycle.
// 3. Same burst with write low 3 cycles after words 10 and 100 -> identical readback; load_busy=1 throughout.
// 4. rd_hold=1 at burst end -> waitrequest stays 1, no load_done, reads return the old bank; release
//    rd_hold -> load_done the next cycle and the new data is readable.
// 5. Burst at addr 195, count 3 -> word 195 stored, 2 words dropped, overflow=1, load_done still pulses.
// 6. rst asserted after 10 words of a 196-word burst -> rd_bank unchanged, reads return the prior image;
//    a fresh 196-word burst completes normally.

Source files
------------

// File: rtl/pixel_pingpong_buffer.sv
// pixel_pingpong_buffer
// Double-buffered pixel store. An Avalon-MM burst-write slave loads 32-bit
// words (PPW packed pixels each) into the write bank while NUM_RD read ports
// serve pixels from the read bank. Completing a burst swaps the two banks,
// so the next image loads while the previous one is being consumed.
// The swap can be held off by the reader (rd_hold); new bursts stall until
// the swap has happened.

module pixel_pingpong_buffer #(
    parameter int PIXEL_W = 8,
    parameter int DEPTH   = 784,
    parameter int NUM_RD  = 2,
    parameter int BC_W    = 10,
    parameter int AW      = 13,
    localparam int PAW    = $clog2(DEPTH)
) (
    input  logic                        clk,
    input  logic                        rst,
    // Avalon-MM burst-write slave
    input  logic                        avs_write,
    input  logic                        avs_beginbursttransfer,
    input  logic [BC_W-1:0]             avs_burstcount,
    input  logic [AW-1:0]               avs_address,
    input  logic [31:0]                 avs_writedata,
    output logic                        avs_waitrequest,
    // pixel read ports
    input  logic                        rd_hold,
    input  logic                        rd_en,
    input  logic [NUM_RD*PAW-1:0]       rd_addr,
    output logic [NUM_RD*PIXEL_W-1:0]   rd_data,
    output logic                        rd_valid,
    // status
    output logic                        load_busy,
    output logic                        load_done,
    output logic                        overflow
);

    // ------------------------------------------------------------------
    // Derived geometry
    // ------------------------------------------------------------------
    localparam int PPW    = 32 / PIXEL_W;      // pixels per Avalon word
    localparam int NWORDS = DEPTH / PPW;       // words per bank
    localparam int LSB_W  = $clog2(PPW);       // pixel lane bits inside a word
    localparam int WIDX_W = $clog2(NWORDS);    // word index width into a bank

    localparam logic [AW-1:0]  NWORDS_A = AW'(NWORDS);
    localparam logic [PAW:0]   DEPTH_A  = (PAW+1)'(DEPTH);

    // ------------------------------------------------------------------
    // Load controller state
    // ------------------------------------------------------------------
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        SWAP  = 2'd2
    } state_t;

    state_t          state;
    state_t          state_next;

    logic            rd_bank;       // bank served to readers; writes go to the other one
    logic [AW-1:0]   wptr;          // word address of the next burst beat
    logic [BC_W-1:0] remaining;     // beats still expected in the current burst

    logic            accept_first;  // first beat of a burst taken in IDLE
    logic            accept_beat;   // subsequent beat taken in BURST
    logic            word_accept;   // any beat stored (or dropped) this cycle
    logic [AW-1:0]   word_addr;     // word address of the beat being accepted
    logic            in_range;      // beat lands inside the bank
    logic            swap_go;       // bank swap happens at the coming edge
    logic [WIDX_W-1:0] wr_widx;

    // Banks are kept as whole 32-bit words; pixel k of a word sits in lane k,
    // which is exactly the packing used on avs_writedata, so no reshuffle
    // is needed on the write side.
    logic [31:0]     mem0 [NWORDS];
    logic [31:0]     mem1 [NWORDS];

    logic [NUM_RD*PIXEL_W-1:0] rd_pix;  // combinational read result, all ports

    // ------------------------------------------------------------------
    // Beat acceptance
    // ------------------------------------------------------------------
    // Reset forces waitrequest high, so nothing is accepted in a reset cycle.
    assign accept_first = (state == IDLE) && avs_write && avs_beginbursttransfer
                          && (avs_burstcount != '0);
    assign accept_beat  = (state == BURST) && avs_write;
    assign word_accept  = !rst && (accept_first || accept_beat);
    assign word_addr    = accept_first ? avs_address : wptr;
    assign in_range     = (word_addr < NWORDS_A);
    assign wr_widx      = WIDX_W'(word_addr);
    assign swap_go      = !rst && (state == SWAP) && !rd_hold;

    // State register for the load controller
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: bursts run to completion, then wait for the swap
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept_first) begin
                    state_next = (avs_burstcount == BC_W'(1)) ? SWAP : BURST;
                end
            end
            BURST: begin
                // beginbursttransfer is deliberately ignored here: it is data
                if (avs_write && (remaining == BC_W'(1))) begin
                    state_next = SWAP;
                end
            end
            SWAP: begin
                if (!rd_hold) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Controller outputs: stall during swap and reset, report progress
    always_comb begin
        avs_waitrequest = 1'b0;
        load_busy       = 1'b0;
        load_done       = 1'b0;
        if (rst) begin
            avs_waitrequest = 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    avs_waitrequest = 1'b0;
                end
                BURST: begin
                    load_busy = 1'b1;
                end
                SWAP: begin
                    avs_waitrequest = 1'b1;
                    load_busy       = 1'b1;
                    load_done       = !rd_hold;
                end
                default: begin
                    avs_waitrequest = 1'b1;
                end
            endcase
        end
    end

    // Burst bookkeeping: next word address and beats left
    always_ff @(posedge clk) begin
        if (word_accept) begin
            wptr      <= word_addr + AW'(1);
            remaining <= accept_first ? (avs_burstcount - BC_W'(1))
                                      : (remaining - BC_W'(1));
        end
    end

    // Bank select flips once per completed burst; reset returns to bank 0
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_bank <= 1'b0;
        end else if (swap_go) begin
            rd_bank <= ~rd_bank;
        end
    end

    // Sticky flag for beats that fell past the end of the bank
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow <= 1'b0;
        end else if (word_accept && !in_range) begin
            overflow <= 1'b1;
        end
    end

    // ---- stage p0: word store into the write bank (never the read bank) ----
    // Bank 0 is written while bank 1 is being read, and vice versa.
    always_ff @(posedge clk) begin
        if (word_accept && in_range && rd_bank) begin
            mem0[wr_widx] <= avs_writedata;
        end
    end

    // Bank 1 receives beats while bank 0 is being read
    always_ff @(posedge clk) begin
        if (word_accept && in_range && !rd_bank) begin
            mem1[wr_widx] <= avs_writedata;
        end
    end

    // ------------------------------------------------------------------
    // Read ports: pixel address -> word index + lane, out-of-range reads 0
    // ------------------------------------------------------------------
    for (genvar j = 0; j < NUM_RD; j++) begin : g_rd
        logic [PAW-1:0]    pix_addr;
        logic [WIDX_W-1:0] widx;
        logic [LSB_W-1:0]  lane;
        logic [31:0]       word;
        logic              valid_addr;

        assign pix_addr   = rd_addr[j*PAW +: PAW];
        assign widx       = WIDX_W'(pix_addr >> LSB_W);
        assign lane       = pix_addr[LSB_W-1:0];
        assign valid_addr = ({1'b0, pix_addr} < DEPTH_A);
        assign word       = rd_bank ? mem1[widx] : mem0[widx];
        assign rd_pix[j*PIXEL_W +: PIXEL_W] =
            valid_addr ? word[lane*PIXEL_W +: PIXEL_W] : '0;
    end

    // ---- stage p1: registered read data, held while rd_en is low ----
    // A read sampled on the swap edge still sees the old rd_bank here.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_valid <= 1'b0;
            rd_data  <= '0;
        end else begin
            rd_valid <= rd_en;
            if (rd_en) begin
                rd_data <= rd_pix;
            end
        end
    end

endmodule

// File: tb/tb_pixel_pingpong_buffer.sv
// tb_pixel_pingpong_buffer
// Randomised bench for the ping-pong pixel buffer. A behavioural model keeps
// two pixel arrays and the bank select, updated from the Avalon beats the
// driver issues; read expectations go into a scoreboard queue and a monitor
// compares them whenever rd_valid is seen.

module tb_pixel_pingpong_buffer;

    localparam int PIXEL_W = 8;
    localparam int DEPTH   = 784;
    localparam int NUM_RD  = 2;
    localparam int BC_W    = 10;
    localparam int AW      = 13;
    localparam int PPW     = 32 / PIXEL_W;
    localparam int NWORDS  = DEPTH / PPW;
    localparam int PAW     = $clog2(DEPTH);

    logic                       clk = 1'b0;
    logic                       rst = 1'b1;
    logic                       avs_write = 1'b0;
    logic                       avs_beginbursttransfer = 1'b0;
    logic [BC_W-1:0]            avs_burstcount = '0;
    logic [AW-1:0]              avs_address = '0;
    logic [31:0]                avs_writedata = '0;
    logic                       avs_waitrequest;
    logic                       rd_hold = 1'b0;
    logic                       rd_en = 1'b0;
    logic [NUM_RD*PAW-1:0]      rd_addr = '0;
    logic [NUM_RD*PIXEL_W-1:0]  rd_data;
    logic                       rd_valid;
    logic                       load_busy;
    logic                       load_done;
    logic                       overflow;

    always #5 clk = ~clk;

    pixel_pingpong_buffer #(
        .PIXEL_W (PIXEL_W),
        .DEPTH   (DEPTH),
        .NUM_RD  (NUM_RD),
        .BC_W    (BC_W),
        .AW      (AW)
    ) dut (
        .clk                    (clk),
        .rst                    (rst),
        .avs_write              (avs_write),
        .avs_beginbursttransfer (avs_beginbursttransfer),
        .avs_burstcount         (avs_burstcount),
        .avs_address            (avs_address),
        .avs_writedata          (avs_writedata),
        .avs_waitrequest        (avs_waitrequest),
        .rd_hold                (rd_hold),
        .rd_en                  (rd_en),
        .rd_addr                (rd_addr),
        .rd_data                (rd_data),
        .rd_valid               (rd_valid),
        .load_busy              (load_busy),
        .load_done              (load_done),
        .overflow               (overflow)
    );

    typedef struct {
        logic [NUM_RD*PIXEL_W-1:0] data;
        logic [NUM_RD-1:0]         care;
    } rd_exp_t;

    rd_exp_t exp_q[$];
    int checks   = 0;
    int failures = 0;

    // behavioural model: images, bank select, loader progress
    logic [PIXEL_W-1:0] mpix   [2][DEPTH];
    bit                 mknown [2][DEPTH];
    int  m_rdbank    = 0;
    int  m_loading   = 0;   // 1 while beats of a burst are still owed
    int  m_swap_wait = 0;   // 1 once the burst is complete but unswapped
    int  m_left      = 0;
    int  m_wptr      = 0;
    bit  m_ovf       = 1'b0;
    bit  m_rdvalid   = 1'b0;
    bit  started     = 1'b0;
    int  done_pulses = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] wdata(input int i, input int mode);
        logic [31:0] d;
        d = '0;
        if (mode == 0) begin
            for (int k = 0; k < PPW; k++) d[k*PIXEL_W +: PIXEL_W] = PIXEL_W'(PPW*i + k);
        end else begin
            d = $urandom;
        end
        return d;
    endfunction

    task automatic store_word(input int w, input logic [31:0] d);
        if (w < NWORDS) begin
            for (int k = 0; k < PPW; k++) begin
                mpix[1-m_rdbank][w*PPW+k]   = d[k*PIXEL_W +: PIXEL_W];
                mknown[1-m_rdbank][w*PPW+k] = 1'b1;
            end
        end else begin
            m_ovf = 1'b1;
        end
    endtask

    task automatic push_read();
        rd_exp_t e;
        int a;
        e.data = '0;
        e.care = '0;
        for (int j = 0; j < NUM_RD; j++) begin
            a = int'(rd_addr[j*PAW +: PAW]);
            if (a >= DEPTH) begin
                e.care[j] = 1'b1;
            end else if (mknown[m_rdbank][a]) begin
                e.care[j] = 1'b1;
                e.data[j*PIXEL_W +: PIXEL_W] = mpix[m_rdbank][a];
            end
        end
        exp_q.push_back(e);
    endtask

    // One clock: check outputs against the model, advance the model, step the clock
    task automatic tick();
        #1;
        if (rst) begin
            check("waitrequest_in_reset", avs_waitrequest, 1);
        end else if (started) begin
            check("waitrequest", avs_waitrequest, m_swap_wait);
            check("load_busy", load_busy, (m_loading | m_swap_wait) != 0);
            check("load_done", load_done, m_swap_wait != 0 && !rd_hold);
            check("overflow", overflow, m_ovf);
            check("rd_valid", rd_valid, m_rdvalid);
        end
        if (!rst && load_done === 1'b1) done_pulses++;
        if (rst) begin
            m_loading = 0; m_swap_wait = 0; m_rdbank = 0; m_ovf = 1'b0;
            m_rdvalid = 1'b0; started = 1'b1;
        end else begin
            if (rd_en) push_read();
            m_rdvalid = rd_en;
            if (m_swap_wait != 0) begin
                if (!rd_hold) begin
                    m_rdbank = 1 - m_rdbank;
                    m_swap_wait = 0;
                end
            end else if (m_loading != 0) begin
                if (avs_write) begin
                    store_word(m_wptr, avs_writedata);
                    m_wptr = (m_wptr + 1) % (1 << AW);
                    m_left--;
                    if (m_left == 0) begin m_loading = 0; m_swap_wait = 1; end
                end
            end else if (avs_write && avs_beginbursttransfer && avs_burstcount != 0) begin
                store_word(int'(avs_address), avs_writedata);
                m_wptr = (int'(avs_address) + 1) % (1 << AW);
                m_left = int'(avs_burstcount) - 1;
                if (m_left == 0) m_swap_wait = 1;
                else             m_loading   = 1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic rnd_reads();
        rd_en = 1'($urandom_range(0, 1));
        for (int j = 0; j < NUM_RD; j++) rd_addr[j*PAW +: PAW] = PAW'($urandom_range(0, DEPTH + 99));
    endtask

    task automatic settle(input int n);
        for (int c = 0; c < n; c++) begin
            rnd_reads();
            tick();
        end
        rd_en = 1'b0;
    endtask

    // abort_at: beat index after which rst is pulsed (-1 = never)
    // release_after: waits in swap before rd_hold is dropped (-1 = never)
    task automatic burst(input int addr, input int cnt, input int mode, input int gap_a,
                         input int gap_b, input int abort_at, input int release_after);
        int waited;
        avs_write = 1'b1;
        avs_beginbursttransfer = 1'b1;
        avs_burstcount = BC_W'(cnt);
        avs_address = AW'(addr);
        avs_writedata = wdata(0, mode);
        waited = 0;
        while (m_swap_wait != 0 || m_loading != 0) begin
            if (waited == release_after) rd_hold = 1'b0;
            rnd_reads();
            tick();
            waited++;
            if (waited > 200) begin
                check("burst_start_timeout", waited, 0);
                break;
            end
        end
        for (int i = 0; i < cnt; i++) begin
            if (i > 0) begin
                avs_write = 1'b1;
                avs_beginbursttransfer = ($urandom_range(0, 7) == 0);
                avs_address = AW'($urandom);
                avs_writedata = wdata(i, mode);
            end
            rnd_reads();
            tick();
            if (i == abort_at) begin
                avs_write = 1'b0;
                rst = 1'b1;
                tick();
                rst = 1'b0;
                avs_beginbursttransfer = 1'b0;
                return;
            end
            if (i == gap_a || i == gap_b) begin
                avs_write = 1'b0;
                avs_writedata = $urandom;
                for (int g = 0; g < 3; g++) begin
                    rnd_reads();
                    tick();
                end
            end
        end
        avs_write = 1'b0;
        avs_beginbursttransfer = 1'b0;
    endtask

    task automatic directed_read();
        logic [NUM_RD*PAW-1:0] a;
        logic [NUM_RD*PIXEL_W-1:0] want;
        a = {PAW'(783), PAW'(5)};
        want = {PIXEL_W'(15), PIXEL_W'(5)};
        rd_en = 1'b1;
        rd_addr = a;
        tick();
        rd_en = 1'b0;
        check("directed_rd_data_783_5", rd_data, want);
        check("directed_rd_valid", rd_valid, 1);
        tick();
    endtask

    // Scoreboard monitor: every rd_valid must match the oldest expected read
    always @(negedge clk) begin
        if (rd_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_rd_valid", 1, 0);
            end else begin
                rd_exp_t e;
                e = exp_q.pop_front();
                for (int j = 0; j < NUM_RD; j++) begin
                    if (e.care[j])
                        check($sformatf("rd_data_port%0d", j),
                              rd_data[j*PIXEL_W +: PIXEL_W], e.data[j*PIXEL_W +: PIXEL_W]);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        // reset: two cycles high
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();
        check("rd_data_after_reset", rd_data, 0);
        check("overflow_after_reset", overflow, 0);
        check("waitrequest_after_reset", avs_waitrequest, 0);

        // ignored requests: write without begin, and burstcount 0
        avs_write = 1'b1;
        avs_writedata = $urandom;
        tick();
        avs_beginbursttransfer = 1'b1;
        avs_burstcount = '0;
        tick();
        avs_write = 1'b0;
        avs_beginbursttransfer = 1'b0;
        tick();
        check("busy_after_ignored", load_busy, 0);

        // full image, no gaps
        done_pulses = 0;
        burst(0, NWORDS, 0, -1, -1, -1, -1);
        settle(2);
        check("load_done_count_plain", done_pulses, 1);
        directed_read();

        // same image with write gaps after beats 10 and 100
        done_pulses = 0;
        burst(0, NWORDS, 0, 10, 100, -1, -1);
        settle(2);
        check("load_done_count_gaps", done_pulses, 1);
        directed_read();

        // random image held back by rd_hold, old bank stays readable
        rd_hold = 1'b1;
        done_pulses = 0;
        burst(0, NWORDS, 1, -1, -1, -1, -1);
        settle(6);
        check("no_load_done_while_held", done_pulses, 0);

        // next burst starts while held; hold released after 3 stalled cycles.
        // It runs off the end of the bank: one beat stored, two dropped.
        burst(NWORDS - 1, 3, 1, -1, -1, -1, 3);
        settle(2);
        check("load_done_count_held_and_overflow", done_pulses, 2);
        check("overflow_sticky", overflow, 1);
        settle(8);

        // reset part-way through a burst: no swap, prior image still served
        done_pulses = 0;
        burst(0, NWORDS, 1, -1, -1, 10, -1);
        settle(20);
        check("overflow_cleared_by_reset", overflow, 0);
        check("no_swap_on_abort", done_pulses, 0);

        // fresh load after the abort
        done_pulses = 0;
        burst(0, NWORDS, 0, -1, -1, -1, -1);
        settle(2);
        check("load_done_count_after_abort", done_pulses, 1);
        directed_read();
        settle(10);

        rd_en = 1'b0;
        tick();
        tick();
        check("scoreboard_drained", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
